// File: rtl/stream_char_arbiter_if.sv
// Byte-stream bundle between the character sources, the arbiter and the UART transmitter.
// The slave side is the arbiter; the master side drives source bytes, downstream ready and pause.
interface stream_char_arbiter_if #(
    parameter int NCH   = 2,
    parameter int DEPTH = 4
);
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int LW = $clog2(DEPTH) + 1;

    logic [NCH-1:0]    i_valid;
    logic [8*NCH-1:0]  i_data;
    logic [NCH-1:0]    o_ready;
    logic              o_valid;
    logic [7:0]        o_data;
    logic [CW-1:0]     o_chan;
    logic              i_ready;
    logic              i_pause;
    logic [NCH*LW-1:0] o_level;

    modport slave (
        input  i_valid, i_data, i_ready, i_pause,
        output o_ready, o_valid, o_data, o_chan, o_level
    );

    modport master (
        output i_valid, i_data, i_ready, i_pause,
        input  o_ready, o_valid, o_data, o_chan, o_level
    );
endinterface

// File: rtl/stream_char_arbiter.sv
// Merges NCH byte streams through per-channel FIFOs into one registered valid/ready output,
// with round-robin or fixed-priority arbitration and an XOFF-style pause on new loads.
module stream_char_arbiter #(
    parameter int NCH       = 2,
    parameter int DEPTH     = 4,
    parameter int PRIO_MODE = 0
) (
    input logic                  i_clk,
    input logic                  i_rst_n,
    stream_char_arbiter_if.slave bus
);
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [7:0]     mem    [NCH][DEPTH];
    logic [AW-1:0]  wr_ptr [NCH];
    logic [AW-1:0]  rd_ptr [NCH];
    logic [LW-1:0]  level  [NCH];
    logic [CW-1:0]  rr_ptr;
    logic [NCH-1:0] ready;
    logic [NCH-1:0] nonempty;
    logic [NCH-1:0] push;
    logic [NCH-1:0] pop;
    logic [CW-1:0]  grant;
    logic [CW-1:0]  idx;
    logic           found;
    logic           load;

    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            ready[k]    = (level[k] != LW'(DEPTH));
            nonempty[k] = (level[k] != '0);
            push[k]     = bus.i_valid[k] & ready[k];
        end
    end

    // Search order starts at rr_ptr in round-robin mode and at channel 0 in priority mode.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int j = 0; j < NCH; j++) begin
            idx = (PRIO_MODE == 1) ? CW'(j) : CW'((int'(rr_ptr) + j) % NCH);
            if (!found && nonempty[idx]) begin
                grant = idx;
                found = 1'b1;
            end
        end
    end

    assign load = (!bus.o_valid | bus.i_ready) & !bus.i_pause & (|nonempty);

    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            pop[k] = load & (grant == CW'(k));
        end
    end

    always_ff @(posedge i_clk) begin
        for (int k = 0; k < NCH; k++) begin
            if (push[k]) begin
                mem[k][wr_ptr[k]] <= bus.i_data[8*k +: 8];
            end
        end
    end

    // Level only moves when exactly one of push/pop happens, so push+pop keeps it constant.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < NCH; k++) begin
                wr_ptr[k] <= '0;
                rd_ptr[k] <= '0;
                level[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < NCH; k++) begin
                if (push[k]) begin
                    wr_ptr[k] <= wr_ptr[k] + AW'(1);
                end
                if (pop[k]) begin
                    rd_ptr[k] <= rd_ptr[k] + AW'(1);
                end
                if (push[k] && !pop[k]) begin
                    level[k] <= level[k] + LW'(1);
                end else if (pop[k] && !push[k]) begin
                    level[k] <= level[k] - LW'(1);
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            bus.o_valid <= 1'b0;
            bus.o_data  <= 8'h00;
            bus.o_chan  <= '0;
            rr_ptr      <= '0;
        end else if (load) begin
            bus.o_valid <= 1'b1;
            bus.o_data  <= mem[grant][rd_ptr[grant]];
            bus.o_chan  <= (NCH > 1) ? grant : '0;
            rr_ptr      <= CW'((int'(grant) + 1) % NCH);
        end else if (bus.o_valid && bus.i_ready) begin
            bus.o_valid <= 1'b0;
        end
    end

    assign bus.o_ready = ready;

    for (genvar k = 0; k < NCH; k++) begin : g_level
        assign bus.o_level[k*LW +: LW] = level[k];
    end
endmodule

// File: tb/tb_stream_char_arbiter.sv
// Drives a round-robin and a fixed-priority arbiter with identical stimulus and checks both
// against directed expectations and a queue-based model of the merging rules.
module tb_stream_char_arbiter;
    localparam int NCH   = 2;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;
    localparam int CW    = (NCH > 1) ? $clog2(NCH) : 1;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic [NCH-1:0]   valid = '0;
    logic [8*NCH-1:0] data  = '0;
    logic             rdy   = 1'b0;
    logic             pause = 1'b0;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    stream_char_arbiter_if #(.NCH(NCH), .DEPTH(DEPTH)) bus_rr ();
    stream_char_arbiter_if #(.NCH(NCH), .DEPTH(DEPTH)) bus_fp ();

    assign bus_rr.i_valid = valid;
    assign bus_rr.i_data  = data;
    assign bus_rr.i_ready = rdy;
    assign bus_rr.i_pause = pause;
    assign bus_fp.i_valid = valid;
    assign bus_fp.i_data  = data;
    assign bus_fp.i_ready = rdy;
    assign bus_fp.i_pause = pause;

    stream_char_arbiter #(.NCH(NCH), .DEPTH(DEPTH), .PRIO_MODE(0)) dut_rr (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus_rr)
    );

    stream_char_arbiter #(.NCH(NCH), .DEPTH(DEPTH), .PRIO_MODE(1)) dut_fp (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus_fp)
    );

    logic              out_valid [2];
    logic [7:0]        out_data  [2];
    logic [CW-1:0]     out_chan  [2];
    logic [NCH-1:0]    out_ready [2];
    logic [NCH*LW-1:0] out_level [2];

    assign out_valid[0] = bus_rr.o_valid;
    assign out_data[0]  = bus_rr.o_data;
    assign out_chan[0]  = bus_rr.o_chan;
    assign out_ready[0] = bus_rr.o_ready;
    assign out_level[0] = bus_rr.o_level;
    assign out_valid[1] = bus_fp.o_valid;
    assign out_data[1]  = bus_fp.o_data;
    assign out_chan[1]  = bus_fp.o_chan;
    assign out_ready[1] = bus_fp.o_ready;
    assign out_level[1] = bus_fp.o_level;

    // Reference model: index 0 is round-robin, index 1 is fixed priority.
    logic [7:0] mq [2][NCH][$];
    logic       mv [2];
    logic [7:0] md [2];
    int         mc [2];
    int         mptr [2];

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            for (int k = 0; k < NCH; k++) mq[m][k].delete();
            mv[m] = 1'b0;
            md[m] = 8'h00;
            mc[m] = 0;
            mptr[m] = 0;
        end
    endtask

    task automatic model_step();
        bit can_push [NCH];
        int g;
        int c;
        if (!rst_n) return;
        for (int m = 0; m < 2; m++) begin
            for (int k = 0; k < NCH; k++) can_push[k] = (mq[m][k].size() != DEPTH);
            g = -1;
            if (!pause && (!mv[m] || rdy)) begin
                for (int j = 0; j < NCH; j++) begin
                    c = (m == 0) ? (mptr[m] + j) % NCH : j;
                    if (g < 0 && mq[m][c].size() != 0) g = c;
                end
            end
            if (g >= 0) begin
                md[m] = mq[m][g].pop_front();
                mc[m] = g;
                mv[m] = 1'b1;
                if (m == 0) mptr[m] = (g + 1) % NCH;
            end else if (mv[m] && rdy) begin
                mv[m] = 1'b0;
            end
            for (int k = 0; k < NCH; k++) begin
                if (valid[k] && can_push[k]) mq[m][k].push_back(data[8*k +: 8]);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rdy   = 1'b1;
        valid = '0;
        pause = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        n_checks++;
        if (bus_rr.o_ready !== 2'b11) begin
            n_fails++;
            $display("[TB] FAIL reset_ready: got %b expected 11", bus_rr.o_ready);
        end
        n_checks++;
        if (bus_rr.o_valid !== 1'b0) begin
            n_fails++;
            $display("[TB] FAIL reset_valid: got %b expected 0", bus_rr.o_valid);
        end
        n_checks++;
        if (bus_rr.o_data !== 8'h00 || bus_rr.o_chan !== '0) begin
            n_fails++;
            $display("[TB] FAIL reset_data_chan: got %h/%0d expected 00/0", bus_rr.o_data, bus_rr.o_chan);
        end
        n_checks++;
        if (bus_rr.o_level !== '0) begin
            n_fails++;
            $display("[TB] FAIL reset_level: got %h expected 0", bus_rr.o_level);
        end
    endtask

    task automatic test_one_byte();
        valid     = 2'b01;
        data[7:0] = 8'h41;
        tick();
        valid = '0;
        n_checks++;
        if (bus_rr.o_valid !== 1'b0) begin
            n_fails++;
            $display("[TB] FAIL one_byte_early: got valid %b expected 0", bus_rr.o_valid);
        end
        tick();
        n_checks++;
        if (bus_rr.o_valid !== 1'b1 || bus_rr.o_data !== 8'h41 || bus_rr.o_chan !== 1'b0) begin
            n_fails++;
            $display("[TB] FAIL one_byte_out: got %b/%h/%0d expected 1/41/0",
                     bus_rr.o_valid, bus_rr.o_data, bus_rr.o_chan);
        end
        tick();
        n_checks++;
        if (bus_rr.o_valid !== 1'b0) begin
            n_fails++;
            $display("[TB] FAIL one_byte_drop: got valid %b expected 0", bus_rr.o_valid);
        end
    endtask

    task automatic test_fill_backpressure();
        rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            valid      = 2'b10;
            data[15:8] = 8'h10 + 8'(i);
            tick();
        end
        valid = '0;
        n_checks++;
        if (bus_rr.o_ready[1] !== 1'b0 || bus_rr.o_level[2*LW-1:LW] !== 3'd4) begin
            n_fails++;
            $display("[TB] FAIL fill_full: got ready %b level %0d expected 0/4",
                     bus_rr.o_ready[1], bus_rr.o_level[2*LW-1:LW]);
        end
        n_checks++;
        if (bus_rr.o_valid !== 1'b1 || bus_rr.o_data !== 8'h10 || bus_rr.o_chan !== 1'b1) begin
            n_fails++;
            $display("[TB] FAIL fill_held: got %b/%h/%0d expected 1/10/1",
                     bus_rr.o_valid, bus_rr.o_data, bus_rr.o_chan);
        end
        rdy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (bus_rr.o_valid !== 1'b1 || bus_rr.o_data !== 8'h10 + 8'(i)) begin
                n_fails++;
                $display("[TB] FAIL drain_%0d: got %b/%h expected 1/%h", i,
                         bus_rr.o_valid, bus_rr.o_data, 8'h10 + 8'(i));
            end
            tick();
            if (i == 0) begin
                n_checks++;
                if (bus_rr.o_ready[1] !== 1'b1) begin
                    n_fails++;
                    $display("[TB] FAIL drain_ready: got %b expected 1", bus_rr.o_ready[1]);
                end
            end
        end
        n_checks++;
        if (bus_rr.o_valid !== 1'b0 || bus_rr.o_level !== '0) begin
            n_fails++;
            $display("[TB] FAIL drain_end: got valid %b level %h expected 0/0",
                     bus_rr.o_valid, bus_rr.o_level);
        end
    endtask

    task automatic test_arbitration();
        logic [7:0] exp_rr_d [4] = '{8'hA0, 8'hB0, 8'hA1, 8'hB1};
        int         exp_rr_c [4] = '{0, 1, 0, 1};
        logic [7:0] exp_fp_d [4] = '{8'hA0, 8'hA1, 8'hB0, 8'hB1};
        int         exp_fp_c [4] = '{0, 0, 1, 1};
        rdy   = 1'b0;
        valid = 2'b11;
        data  = {8'hB0, 8'hA0};
        tick();
        data  = {8'hB1, 8'hA1};
        tick();
        valid = '0;
        rdy   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (out_valid[0] !== 1'b1 || out_data[0] !== exp_rr_d[i] || int'(out_chan[0]) != exp_rr_c[i]) begin
                n_fails++;
                $display("[TB] FAIL rr_order_%0d: got %b/%h/%0d expected 1/%h/%0d", i,
                         out_valid[0], out_data[0], out_chan[0], exp_rr_d[i], exp_rr_c[i]);
            end
            n_checks++;
            if (out_valid[1] !== 1'b1 || out_data[1] !== exp_fp_d[i] || int'(out_chan[1]) != exp_fp_c[i]) begin
                n_fails++;
                $display("[TB] FAIL fp_order_%0d: got %b/%h/%0d expected 1/%h/%0d", i,
                         out_valid[1], out_data[1], out_chan[1], exp_fp_d[i], exp_fp_c[i]);
            end
            tick();
        end
        n_checks++;
        if (out_valid[0] !== 1'b0 || out_valid[1] !== 1'b0) begin
            n_fails++;
            $display("[TB] FAIL arb_end: got valid %b/%b expected 0/0", out_valid[0], out_valid[1]);
        end
    endtask

    task automatic test_pause();
        rdy       = 1'b0;
        valid     = 2'b01;
        data[7:0] = 8'h55;
        tick();
        data[7:0] = 8'h56;
        tick();
        valid = '0;
        pause = 1'b1;
        tick();
        n_checks++;
        if (bus_rr.o_valid !== 1'b1 || bus_rr.o_data !== 8'h55) begin
            n_fails++;
            $display("[TB] FAIL pause_hold: got %b/%h expected 1/55", bus_rr.o_valid, bus_rr.o_data);
        end
        rdy = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (bus_rr.o_valid !== 1'b0) begin
                n_fails++;
                $display("[TB] FAIL pause_block_%0d: got valid %b expected 0", i, bus_rr.o_valid);
            end
            tick();
        end
        n_checks++;
        if (bus_rr.o_level[LW-1:0] !== 3'd1) begin
            n_fails++;
            $display("[TB] FAIL pause_level: got %0d expected 1", bus_rr.o_level[LW-1:0]);
        end
        pause = 1'b0;
        tick();
        n_checks++;
        if (bus_rr.o_valid !== 1'b1 || bus_rr.o_data !== 8'h56) begin
            n_fails++;
            $display("[TB] FAIL pause_release: got %b/%h expected 1/56", bus_rr.o_valid, bus_rr.o_data);
        end
        tick();
    endtask

    task automatic test_async_reset();
        rdy   = 1'b0;
        valid = 2'b11;
        for (int i = 0; i < 3; i++) begin
            data = 16'($urandom);
            tick();
        end
        valid = '0;
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        for (int m = 0; m < 2; m++) begin
            n_checks++;
            if (out_valid[m] !== 1'b0 || out_level[m] !== '0 || out_ready[m] !== 2'b11) begin
                n_fails++;
                $display("[TB] FAIL async_reset_%0d: got valid %b level %h ready %b expected 0/0/11",
                         m, out_valid[m], out_level[m], out_ready[m]);
            end
        end
        #2 rst_n = 1'b1;
        rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if (out_valid[0] !== 1'b0 || out_valid[1] !== 1'b0) begin
                n_fails++;
                $display("[TB] FAIL stale_%0d: got valid %b/%b expected 0/0", i, out_valid[0], out_valid[1]);
            end
        end
        valid      = 2'b10;
        data[15:8] = 8'h77;
        tick();
        valid = '0;
        tick();
        n_checks++;
        if (bus_rr.o_valid !== 1'b1 || bus_rr.o_data !== 8'h77 || bus_rr.o_chan !== 1'b1) begin
            n_fails++;
            $display("[TB] FAIL post_reset: got %b/%h/%0d expected 1/77/1",
                     bus_rr.o_valid, bus_rr.o_data, bus_rr.o_chan);
        end
        tick();
    endtask

    task automatic test_random();
        logic [NCH-1:0]    exp_ready;
        logic [NCH*LW-1:0] exp_level;
        for (int cyc = 0; cyc < 620; cyc++) begin
            if (cyc < 600) begin
                valid = NCH'($urandom);
                data  = 16'($urandom);
                rdy   = (cyc < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
                pause = ($urandom_range(0, 9) == 0);
            end else begin
                valid = '0;
                rdy   = 1'b1;
                pause = 1'b0;
            end
            tick();
            for (int m = 0; m < 2; m++) begin
                for (int k = 0; k < NCH; k++) begin
                    exp_ready[k]           = (mq[m][k].size() != DEPTH);
                    exp_level[k*LW +: LW]  = LW'(mq[m][k].size());
                end
                n_checks++;
                if (out_valid[m] !== mv[m]) begin
                    n_fails++;
                    $display("[TB] FAIL rand_valid m%0d c%0d: got %b expected %b", m, cyc, out_valid[m], mv[m]);
                end
                n_checks++;
                if (out_data[m] !== md[m] || int'(out_chan[m]) != mc[m]) begin
                    n_fails++;
                    $display("[TB] FAIL rand_data m%0d c%0d: got %h/%0d expected %h/%0d",
                             m, cyc, out_data[m], out_chan[m], md[m], mc[m]);
                end
                n_checks++;
                if (out_ready[m] !== exp_ready || out_level[m] !== exp_level) begin
                    n_fails++;
                    $display("[TB] FAIL rand_level m%0d c%0d: got %b/%h expected %b/%h",
                             m, cyc, out_ready[m], out_level[m], exp_ready, exp_level);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_one_byte();
        test_fill_backpressure();
        test_arbitration();
        test_pause();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
